// File: rtl/decoder_3x8_stream_pkg.sv
// Shared types and decode helpers for decoder_3x8_stream.
// Codes and one-hot vectors are carried at a fixed maximum width so that
// callers with any IN_W <= MAX_IN_W can use the helpers and cast down.
package decoder_pkg;

  localparam int unsigned MAX_IN_W = 8;
  localparam int unsigned MAX_OUT  = 2 ** MAX_IN_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic code_legal(input logic [MAX_IN_W-1:0] code,
                                      input int unsigned num_out);
    return (32'(code) < num_out);
  endfunction

  // One-hot select for a legal code, all zeros for an illegal one.
  function automatic logic [MAX_OUT-1:0] onehot_of(input logic [MAX_IN_W-1:0] code,
                                                   input int unsigned num_out);
    logic [MAX_OUT-1:0] r;
    r = '0;
    if (code_legal(code, num_out)) r = MAX_OUT'(1) << code;
    return r;
  endfunction

endpackage

// File: rtl/decoder_3x8_stream_if.sv
// Handshake bundle for decoder_3x8_stream.
// DECODER_RANGE_ERR_EN adds out_err to the bundle and both modports.
interface decoder_3x8_stream_if #(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned NUM_OUT = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_code;
  logic               scan_start;
  logic               scan_busy;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_onehot;
  logic [IN_W-1:0]    out_code;
`ifdef DECODER_RANGE_ERR_EN
  logic               out_err;
`endif

  modport master (
    output in_valid, in_code, scan_start, out_ready,
    input  in_ready, scan_busy, out_valid, out_onehot, out_code
`ifdef DECODER_RANGE_ERR_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_valid, in_code, scan_start, out_ready,
    output in_ready, scan_busy, out_valid, out_onehot, out_code
`ifdef DECODER_RANGE_ERR_EN
    , output out_err
`endif
  );

endinterface

// File: rtl/decoder_3x8_stream_out_slice.sv
// Single-entry valid/ready register slice for decoder results.
// The caller only asserts load when slot_free is high.
module dec_out_slice #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] q,
  output logic         slot_free
);

  assign slot_free = !out_valid || out_ready;

  // Hold one result; a drain without reload clears valid but keeps the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      q         <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder_3x8_stream.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a
// self-driven scan that walks every legal one-hot pattern in ascending order.
// Optional macro DECODER_RANGE_ERR_EN: illegal codes produce an error result
// (out_onehot=0, out_err=1) instead of being silently consumed.
module decoder_3x8_stream
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned NUM_OUT = 8
) (
  input logic                 clk,
  input logic                 rst,
  decoder_3x8_stream_if.slave bus
);

`ifdef DECODER_RANGE_ERR_EN
  localparam int unsigned SW = NUM_OUT + IN_W + 1;
`else
  localparam int unsigned SW = NUM_OUT + IN_W;
`endif
  localparam logic [IN_W-1:0] LAST_CODE = IN_W'(NUM_OUT - 1);

  state_t             state_q, state_d;
  logic [IN_W-1:0]    cnt_q, cnt_d;
  logic               slot_free;
  logic               in_ready_c;
  logic               load;
  logic [IN_W-1:0]    ld_code;
  logic [NUM_OUT-1:0] ld_onehot;
  logic [SW-1:0]      slice_d, slice_q;

  // State and scan counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, input acceptance and slice load selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    ld_code    = bus.in_code;
    unique case (state_q)
      IDLE: begin
        in_ready_c = slot_free && !bus.scan_start;
        if (bus.scan_start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (bus.in_valid && in_ready_c) begin
`ifdef DECODER_RANGE_ERR_EN
          load = 1'b1;
`else
          // Illegal codes complete the handshake but produce no result.
          load = code_legal(MAX_IN_W'(bus.in_code), NUM_OUT);
`endif
        end
      end
      SCAN: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_code = cnt_q;
          cnt_d   = cnt_q + IN_W'(1);
          if (cnt_q == LAST_CODE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_onehot = NUM_OUT'(onehot_of(MAX_IN_W'(ld_code), NUM_OUT));

`ifdef DECODER_RANGE_ERR_EN
  assign slice_d     = {!code_legal(MAX_IN_W'(ld_code), NUM_OUT), ld_onehot, ld_code};
  assign bus.out_err = slice_q[SW-1];
`else
  assign slice_d = {ld_onehot, ld_code};
`endif

  dec_out_slice #(.W(SW)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .d         (slice_d),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .q         (slice_q),
    .slot_free (slot_free)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.scan_busy  = (state_q == SCAN);
  assign bus.out_onehot = slice_q[IN_W +: NUM_OUT];
  assign bus.out_code   = slice_q[IN_W-1:0];

endmodule

// File: tb/tb_decoder_3x8_stream.sv
// Self-checking bench for decoder_3x8_stream: directed steps plus a random
// phase, checked every cycle against a queue-based behavioural model.
module tb_decoder_3x8_stream;

  logic clk;
  logic rst;

  decoder_3x8_stream_if #(.IN_W(3), .NUM_OUT(8)) b8 ();
  decoder_3x8_stream_if #(.IN_W(3), .NUM_OUT(6)) b6 ();

  decoder_3x8_stream #(.IN_W(3), .NUM_OUT(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  decoder_3x8_stream #(.IN_W(3), .NUM_OUT(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the 8-output instance.
  bit         m_valid;
  logic [7:0] m_oh;
  logic [2:0] m_code;
  int         scan_q[$];     // codes still to be emitted by an active scan
  bit         m_scan;
  int         nxfer;
  logic [7:0] xfer_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_scan  = 1'b0;
    scan_q.delete();
  endtask

  // One clock: check b8 mid-cycle against the model, advance the model, then
  // move to 1 time unit after the next rising edge.
  task automatic tick();
    bit         sf, exp_ir, nv;
    logic [7:0] noh;
    logic [2:0] nc;
    int         c;
    #3;
    sf     = !m_valid || b8.out_ready;
    exp_ir = !m_scan && sf && !b8.scan_start;
    chk("in_ready", b8.in_ready, exp_ir);
    chk("scan_busy", b8.scan_busy, m_scan);
    chk("out_valid", b8.out_valid, m_valid);
    if (m_valid) begin
      chk("out_onehot", b8.out_onehot, m_oh);
      chk("out_code", b8.out_code, m_code);
`ifdef DECODER_RANGE_ERR_EN
      chk("out_err", b8.out_err, 0);
`endif
    end
    if (b8.out_valid && b8.out_ready) begin
      nxfer++;
      xfer_q.push_back(b8.out_onehot);
    end
    nv = 1'b0;
    if (m_scan) begin
      if (sf) begin
        c   = scan_q.pop_front();
        nv  = 1'b1;
        noh = 8'(1 << c);
        nc  = 3'(c);
        if (scan_q.size() == 0) m_scan = 1'b0;
      end
    end else if (b8.scan_start) begin
      m_scan = 1'b1;
      for (int i = 0; i < 8; i++) scan_q.push_back(i);
    end else if (b8.in_valid && exp_ir && b8.in_code < 8) begin
      nv  = 1'b1;
      noh = 8'(1 << b8.in_code);
      nc  = b8.in_code;
    end
    if (nv) begin
      m_valid = 1'b1;
      m_oh    = noh;
      m_code  = nc;
    end else if (b8.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    b8.in_valid = 0; b8.in_code = 0; b8.scan_start = 0; b8.out_ready = 0;
    b6.in_valid = 0; b6.in_code = 0; b6.scan_start = 0; b6.out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_onehot", b8.out_onehot, 0);
    chk("rst_out_code", b8.out_code, 0);
    chk("rst_scan_busy", b8.scan_busy, 0);
`ifdef DECODER_RANGE_ERR_EN
    chk("rst_out_err", b8.out_err, 0);
`endif
    rst = 1'b0;
    tick();

    // Single input, latency 1.
    b8.out_ready = 1; b8.in_valid = 1; b8.in_code = 3'd5;
    tick();
    b8.in_valid = 0;
    chk("single_valid", b8.out_valid, 1);
    chk("single_onehot", b8.out_onehot, 8'b0010_0000);
    chk("single_code", b8.out_code, 5);
    tick();

    // Streaming 0..7 with no bubbles.
    for (int i = 0; i < 8; i++) begin
      b8.in_valid = 1; b8.in_code = 3'(i);
      tick();
      chk("stream_valid", b8.out_valid, 1);
      chk("stream_onehot", b8.out_onehot, 32'(1 << i));
    end
    b8.in_valid = 0;
    tick();

    // Backpressure: result stays stable, new input is refused.
    b8.in_valid = 1; b8.in_code = 3'd2; b8.out_ready = 1;
    tick();
    b8.in_code = 3'd6; b8.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_onehot", b8.out_onehot, 8'h04);
      chk("bp_in_ready", b8.in_ready, 0);
    end
    b8.in_valid = 0; b8.out_ready = 1;
    nxfer = 0;
    tick();
    chk("bp_one_xfer", nxfer, 1);
    chk("bp_valid_drop", b8.out_valid, 0);

    // Scan wins over a same-cycle input.
    xfer_q.delete();
    b8.scan_start = 1; b8.in_valid = 1; b8.in_code = 3'd3;
    #1;
    chk("scan_start_in_ready", b8.in_ready, 0);
    tick();
    b8.scan_start = 0; b8.in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("scan_count", xfer_q.size(), 8);
    for (int i = 0; i < 8 && i < xfer_q.size(); i++)
      chk("scan_order", xfer_q[i], 32'(1 << i));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      b8.in_valid   = 1'($urandom_range(0, 1));
      b8.in_code    = 3'($urandom_range(0, 7));
      b8.out_ready  = ($urandom_range(0, 3) != 0);
      b8.scan_start = ($urandom_range(0, 19) == 0);
      tick();
    end
    b8.in_valid = 0; b8.scan_start = 0; b8.out_ready = 1;
    for (int i = 0; i < 12; i++) tick();

    // Reset in the middle of a scan, after three outputs.
    nxfer = 0;
    b8.scan_start = 1;
    tick();
    b8.scan_start = 0;
    budget = 20;
    while (nxfer < 3 && budget > 0) begin
      tick();
      budget--;
    end
    chk("midscan_budget", (nxfer >= 3), 1);
    rst = 1'b1;
    #1;
    chk("midscan_rst_valid", b8.out_valid, 0);
    chk("midscan_rst_busy", b8.scan_busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    b8.scan_start = 1;
    tick();
    b8.scan_start = 0;
    tick();
    chk("rescan_code", b8.out_code, 0);
    chk("rescan_onehot", b8.out_onehot, 8'h01);
    for (int i = 0; i < 10; i++) tick();

    // NUM_OUT=6 instance: illegal code 7, then legal code 5.
    b6.in_valid = 1; b6.in_code = 3'd7;
    #1;
    chk("d6_illegal_in_ready", b6.in_ready, 1);
    tick();
    b6.in_valid = 0;
`ifdef DECODER_RANGE_ERR_EN
    chk("d6_err_valid", b6.out_valid, 1);
    chk("d6_err_onehot", b6.out_onehot, 0);
    chk("d6_err_code", b6.out_code, 7);
    chk("d6_err_flag", b6.out_err, 1);
`else
    chk("d6_illegal_no_valid", b6.out_valid, 0);
`endif
    tick();
    b6.in_valid = 1; b6.in_code = 3'd5;
    tick();
    b6.in_valid = 0;
    chk("d6_legal_valid", b6.out_valid, 1);
    chk("d6_legal_onehot", b6.out_onehot, 6'b10_0000);
    chk("d6_legal_code", b6.out_code, 5);
`ifdef DECODER_RANGE_ERR_EN
    chk("d6_legal_err", b6.out_err, 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
